alu_sequencer: RTL and testbench

- Micro-sequencer that owns a small register file and drives the combinational ArithmeticLogicUnit one instruction at a time.
- Accepts packed instructions over a valid/ready handshake and presents operands, opcode, immediate and current flags to the ALU.
- Captures OutDest/OutFlags and writes them back to the register file and flag register.
- Sits between a command source (switch/key front-end or test driver) and the ALU on the DE1-SoC build.

---
 rtl/alu_sequencer_if.sv | 40 ++++
 rtl/alu_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Instruction handshake and ALU operand/result bus between a command source/ALU pair and alu_sequencer.
// The slave modport is the sequencer view. The master modport is the environment view: the command source plus the ALU.
interface alu_sequencer_if #(
  parameter int DataWidth = 4,
  parameter int NumRegs   = 4,
  parameter int ImmWidth  = 2,
  parameter int FlagWidth = 5
);
  localparam int AddrWidth = $clog2(NumRegs);

  logic                 InstrValid;
  logic                 InstrReady;
  logic [3:0]           InstrOp;
  logic [AddrWidth-1:0] InstrDest;
  logic [AddrWidth-1:0] InstrSrc;
  logic [ImmWidth-1:0]  InstrImm;
  logic                 InstrWbEn;

  logic [3:0]           AluOperation;
  logic [DataWidth-1:0] AluInSrc;
  logic [DataWidth-1:0] AluInDest;
  logic [ImmWidth-1:0]  AluInImm;
  logic [FlagWidth-1:0] AluInFlags;
  logic [DataWidth-1:0] AluOutDest;
  logic [FlagWidth-1:0] AluOutFlags;

  modport master (
    output InstrValid, InstrOp, InstrDest, InstrSrc, InstrImm, InstrWbEn,
    output AluOutDest, AluOutFlags,
    input  InstrReady,
    input  AluOperation, AluInSrc, AluInDest, AluInImm, AluInFlags
  );

  modport slave (
    input  InstrValid, InstrOp, InstrDest, InstrSrc, InstrImm, InstrWbEn,
    input  AluOutDest, AluOutFlags,
    output InstrReady,
    output AluOperation, AluInSrc, AluInDest, AluInImm, AluInFlags
  );
endinterface

// File: rtl/alu_sequencer.sv
// Three-state (IDLE/EXEC/WB) micro-sequencer: issues one instruction to an external combinational ALU and writes back.
// Define ALU_SEQ_PERF_EN to add the InstrCount and BusyCycles performance counters.
module alu_sequencer #(
  parameter int DataWidth = 4,
  parameter int NumRegs   = 4,
  parameter int ImmWidth  = 2,
  parameter int FlagWidth = 5,
  localparam int AddrWidth = $clog2(NumRegs)
) (
  input  logic                 Clock,
  input  logic                 nReset,
  alu_sequencer_if.slave       bus,
  output logic                 Done,
  output logic [FlagWidth-1:0] Flags,
  input  logic [AddrWidth-1:0] RdAddr,
  output logic [DataWidth-1:0] RdData
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0]          InstrCount,
  output logic [15:0]          BusyCycles
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 accept;

  logic [AddrWidth-1:0] dest_q;
  logic                 wb_en_q;
  logic [3:0]           alu_op_q;
  logic [DataWidth-1:0] alu_dest_q;
  logic [DataWidth-1:0] alu_src_q;
  logic [ImmWidth-1:0]  alu_imm_q;
  logic [FlagWidth-1:0] alu_flags_q;

  logic [DataWidth-1:0] res_q;
  logic [FlagWidth-1:0] res_flags_q;

  logic [DataWidth-1:0] regs [NumRegs];
  logic [FlagWidth-1:0] flags_q;

  // NOTE: sequential state is assigned with <= only, so every flop samples the values from before the edge.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: the default assignment before the case keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.InstrValid) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.InstrReady = (state_q == IDLE);
    Done           = (state_q == WB);
  end

  assign accept = bus.InstrValid && bus.InstrReady;

  // Operands are read at accept. Regs cannot change before EXEC because issue is serialised.
  // These registers also hold the Alu* outputs stable through WB and IDLE.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      dest_q      <= '0;
      wb_en_q     <= 1'b0;
      alu_op_q    <= '0;
      alu_dest_q  <= '0;
      alu_src_q   <= '0;
      alu_imm_q   <= '0;
      alu_flags_q <= '0;
    end else if (accept) begin
      dest_q      <= bus.InstrDest;
      wb_en_q     <= bus.InstrWbEn;
      alu_op_q    <= bus.InstrOp;
      alu_dest_q  <= regs[bus.InstrDest];
      alu_src_q   <= regs[bus.InstrSrc];
      alu_imm_q   <= bus.InstrImm;
      alu_flags_q <= flags_q;
    end
  end

  assign bus.AluOperation = alu_op_q;
  assign bus.AluInDest    = alu_dest_q;
  assign bus.AluInSrc     = alu_src_q;
  assign bus.AluInImm     = alu_imm_q;
  assign bus.AluInFlags   = alu_flags_q;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      res_q       <= '0;
      res_flags_q <= '0;
    end else if (state_q == EXEC) begin
      res_q       <= bus.AluOutDest;
      res_flags_q <= bus.AluOutFlags;
    end
  end

  // NOTE: the register file is reset explicitly, because software relies on every register reading zero after reset.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
      flags_q <= '0;
    end else if (state_q == WB) begin
      flags_q <= res_flags_q;
      if (wb_en_q) regs[dest_q] <= res_q;
    end
  end

  assign Flags  = flags_q;
  assign RdData = regs[RdAddr];

`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      InstrCount <= '0;
      BusyCycles <= '0;
    end else begin
      if (state_q == WB)   InstrCount <= InstrCount + 16'd1;
      if (state_q != IDLE) BusyCycles <= BusyCycles + 16'd1;
    end
  end
`endif

  a_valid_known: assert property (@(posedge Clock) disable iff (!nReset)
    (state_q == IDLE) |-> !$isunknown(bus.InstrValid));

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a stub ALU, a directed vector table, reset abort and randomized back-to-back bursts.
// The bursts are checked against a register-file reference model. The counter check is compiled only with ALU_SEQ_PERF_EN.
module tb_alu_sequencer;
  localparam int DW = 4;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int FW = 5;
  localparam int AW = 2;
  localparam int Mod  = 1 << DW;
  localparam int SMax = Mod / 2 - 1;
  localparam int SMin = -(Mod / 2);

  typedef struct {
    logic [3:0]    op;
    logic [AW-1:0] dest;
    logic [AW-1:0] src;
    logic [IW-1:0] imm;
    logic          wb;
    logic [DW-1:0] exp_reg;
    logic [FW-1:0] exp_flags;
  } vec_t;

  logic          Clock = 1'b0;
  logic          nReset;
  logic          Done;
  logic [FW-1:0] Flags;
  logic [AW-1:0] RdAddr;
  logic [DW-1:0] RdData;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0]   InstrCount;
  logic [15:0]   BusyCycles;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  alu_sequencer_if #(.DataWidth(DW), .NumRegs(NR), .ImmWidth(IW), .FlagWidth(FW)) bus ();

  alu_sequencer #(.DataWidth(DW), .NumRegs(NR), .ImmWidth(IW), .FlagWidth(FW)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus),
    .Done   (Done),
    .Flags  (Flags),
    .RdAddr (RdAddr),
    .RdData (RdData)
`ifdef ALU_SEQ_PERF_EN
    ,
    .InstrCount (InstrCount),
    .BusyCycles (BusyCycles)
`endif
  );

  // Stub ALU. Ops: 1 add, 2 sub, 3 load imm, 4 add with carry, others xor.
  // Flags: [0]=carry/borrow, [1]=zero, [2]=negative, [3]=signed overflow, [4]=parity.
  function automatic logic [FW+DW-1:0] alu_ref(input logic [3:0] op, input logic [DW-1:0] d,
                                               input logic [DW-1:0] s, input logic [IW-1:0] imm,
                                               input logic [FW-1:0] fin);
    int ud, us, sd, ss, u, sg;
    logic [DW-1:0] r;
    logic c, v;
    ud = int'(d);
    us = int'(s);
    sd = d[DW-1] ? ud - Mod : ud;
    ss = s[DW-1] ? us - Mod : us;
    c = 1'b0;
    v = 1'b0;
    u = 0;
    sg = 0;
    case (op)
      4'd1, 4'd4: begin
        u  = ud + us + ((op == 4'd4) ? int'(fin[0]) : 0);
        sg = sd + ss + ((op == 4'd4) ? int'(fin[0]) : 0);
        r  = u[DW-1:0];
        c  = (u >= Mod);
        v  = (sg > SMax) || (sg < SMin);
      end
      4'd2: begin
        u  = ud - us;
        sg = sd - ss;
        r  = u[DW-1:0];
        c  = (ud < us);
        v  = (sg > SMax) || (sg < SMin);
      end
      4'd3:    r = DW'(imm);
      default: r = d ^ s;
    endcase
    return {^r, v, r[DW-1], (r == '0), c, r};
  endfunction

  always_comb begin
    {bus.AluOutFlags, bus.AluOutDest} = alu_ref(bus.AluOperation, bus.AluInDest, bus.AluInSrc,
                                                bus.AluInImm, bus.AluInFlags);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.InstrOp   = v.op;
    bus.InstrDest = v.dest;
    bus.InstrSrc  = v.src;
    bus.InstrImm  = v.imm;
    bus.InstrWbEn = v.wb;
  endtask

  // Entered at a negedge with the DUT idle. Returns at the negedge after the writeback.
  task automatic run_vec(input vec_t v, input logic [FW-1:0] prev_flags);
    drive(v);
    bus.InstrValid = 1'b1;
    RdAddr = v.dest;
    check("idle_ready", bus.InstrReady, 1);
    @(posedge Clock);
    @(negedge Clock);
    bus.InstrValid = 1'b0;
    bus.InstrOp    = 4'($urandom);
    bus.InstrDest  = AW'($urandom);
    bus.InstrSrc   = AW'($urandom);
    bus.InstrWbEn  = 1'($urandom);
    check("exec_ready", bus.InstrReady, 0);
    check("exec_done", Done, 0);
    check("exec_op", bus.AluOperation, v.op);
    check("exec_imm", bus.AluInImm, v.imm);
    check("exec_in_flags", bus.AluInFlags, prev_flags);
    @(negedge Clock);
    check("wb_done", Done, 1);
    check("wb_ready", bus.InstrReady, 0);
    @(negedge Clock);
    check("post_done", Done, 0);
    check("rd_data", RdData, v.exp_reg);
    check("flags", Flags, v.exp_flags);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got no summary, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[15];
    vec_t q[4];
    logic [DW-1:0] m_regs[NR];
    logic [FW-1:0] m_flags;
    logic [FW-1:0] prev;
    logic [FW+DW-1:0] fr;
    int k, n_done;
    logic rdy;

    tbl[0]  = '{4'd3, 2'd0, 2'd0, 2'd2, 1'b1, 4'd2, 5'h10};
    tbl[1]  = '{4'd3, 2'd1, 2'd0, 2'd3, 1'b1, 4'd3, 5'h00};
    tbl[2]  = '{4'd1, 2'd0, 2'd1, 2'd0, 1'b1, 4'd5, 5'h00};
    tbl[3]  = '{4'd3, 2'd2, 2'd0, 2'd3, 1'b1, 4'd3, 5'h00};
    tbl[4]  = '{4'd3, 2'd3, 2'd0, 2'd1, 1'b1, 4'd1, 5'h10};
    tbl[5]  = '{4'd1, 2'd2, 2'd2, 2'd0, 1'b1, 4'd6, 5'h00};
    tbl[6]  = '{4'd1, 2'd2, 2'd3, 2'd0, 1'b1, 4'd7, 5'h10};
    tbl[7]  = '{4'd1, 2'd2, 2'd3, 2'd0, 1'b1, 4'd8, 5'h1C};
    tbl[8]  = '{4'd2, 2'd0, 2'd0, 2'd0, 1'b0, 4'd5, 5'h02};
    tbl[9]  = '{4'd3, 2'd0, 2'd0, 2'd3, 1'b1, 4'd3, 5'h00};
    tbl[10] = '{4'd1, 2'd0, 2'd0, 2'd0, 1'b1, 4'd6, 5'h00};
    tbl[11] = '{4'd3, 2'd1, 2'd0, 2'd1, 1'b1, 4'd1, 5'h10};
    tbl[12] = '{4'd1, 2'd0, 2'd1, 2'd0, 1'b1, 4'd7, 5'h10};
    tbl[13] = '{4'd1, 2'd2, 2'd2, 2'd0, 1'b0, 4'd8, 5'h0B};
    tbl[14] = '{4'd4, 2'd0, 2'd1, 2'd0, 1'b1, 4'd9, 5'h0C};

    nReset = 1'b0;
    bus.InstrValid = 1'b0;
    bus.InstrOp = '0;
    bus.InstrDest = '0;
    bus.InstrSrc = '0;
    bus.InstrImm = '0;
    bus.InstrWbEn = 1'b0;
    RdAddr = '0;
    @(negedge Clock);
    @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);
    check("rst_ready", bus.InstrReady, 1);
    check("rst_done", Done, 0);
    check("rst_flags", Flags, 0);
    check("rst_alu_op", bus.AluOperation, 0);
    check("rst_alu_dest", bus.AluInDest, 0);
    check("rst_alu_flags", bus.AluInFlags, 0);
    check("rst_rd_data", RdData, 0);

    prev = '0;
    for (int i = 0; i < 15; i++) begin
      run_vec(tbl[i], prev);
      prev = tbl[i].exp_flags;
    end

    // Reset asserted in the middle of EXEC aborts the instruction.
    drive('{4'd3, 2'd3, 2'd0, 2'd2, 1'b1, 4'd0, 5'h00});
    bus.InstrValid = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    bus.InstrValid = 1'b0;
    nReset = 1'b0;
    #1;
    check("abort_done", Done, 0);
    check("abort_flags", Flags, 0);
    check("abort_alu_op", bus.AluOperation, 0);
    check("abort_alu_src", bus.AluInSrc, 0);
    @(negedge Clock);
    @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);
    check("abort_ready", bus.InstrReady, 1);
    check("abort_done_rel", Done, 0);
    for (int i = 0; i < NR; i++) begin
      RdAddr = AW'(i);
      #1;
      check("abort_reg", RdData, 0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("abort_no_done", Done, 0);
    end

    // Back-to-back random bursts with InstrValid held high.
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_flags = '0;
    for (int b = 0; b < 20; b++) begin
      for (int j = 0; j < 4; j++) begin
        q[j] = '{4'($urandom_range(0, 5)), AW'($urandom), AW'($urandom), IW'($urandom),
                 1'($urandom), '0, '0};
        fr = alu_ref(q[j].op, m_regs[q[j].dest], m_regs[q[j].src], q[j].imm, m_flags);
        m_flags = fr[FW+DW-1:DW];
        if (q[j].wb) m_regs[q[j].dest] = fr[DW-1:0];
      end
      k = 0;
      n_done = 0;
      drive(q[0]);
      bus.InstrValid = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
        rdy = bus.InstrReady;
        check("bp_ready", rdy, ((cyc % 3) == 0));
        if (Done) n_done++;
        @(negedge Clock);
        if (rdy) begin
          k++;
          if (k < 4) drive(q[k]);
          else bus.InstrValid = 1'b0;
        end
      end
      bus.InstrValid = 1'b0;
      check("bp_done_count", n_done, 4);
      check("bp_flags", Flags, m_flags);
`ifdef ALU_SEQ_PERF_EN
      if (b == 0) begin
        check("perf_instr_count", InstrCount, 4);
        check("perf_busy_cycles", BusyCycles, 8);
      end
`endif
      for (int i = 0; i < NR; i++) begin
        RdAddr = AW'(i);
        #1;
        check("bp_reg", RdData, m_regs[i]);
      end
      @(negedge Clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
